// File: rtl/q_update_seq.sv
// q_update_seq: reads Q(s,a) and Q(s',0..3) from the Q-table RAM, applies the
// saturating Q8.8 Bellman update and writes the result back to Q(s,a).
module q_update_seq #(
  parameter int STATES = 25
) (
  input  logic        clk,
  input  logic        enb,
  input  logic        start,
  input  logic [5:0]  cur_st,
  input  logic [3:0]  act,
  input  logic [5:0]  next_st,
  input  logic        terminal,
  input  logic [15:0] reward,
  input  logic [3:0]  alpha,
  input  logic [3:0]  gamma,
  output logic [7:0]  q_addr,
  output logic        q_rd_en,
  input  logic [15:0] q_rdata,
  output logic        q_wr_en,
  output logic [15:0] q_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [3:0] {IDLE, RDC, RN0, RN1, RN2, RN3, WAIT, CALC, WR} state_t;
  state_t st;
  logic [5:0] cs_r, ns_r;
  logic [1:0] ac_r;
  logic [3:0] a_r, g_r;
  logic t_r;
  logic signed [15:0] rw_r, qsa, mx, rd, mx_nx, sat;
  logic signed [19:0] gm, t, d, ad, n;
  logic bad;
  assign rd = q_rdata;
  assign mx_nx = rd > mx ? rd : mx;
  assign bad = cur_st == 6'd0 || cur_st > 6'(STATES) || next_st == 6'd0 ||
               next_st > 6'(STATES) || act > 4'd3;
  assign gm = $signed({16'd0, g_r}) * $signed({{4{mx[15]}}, mx});
  assign t = $signed({{4{rw_r[15]}}, rw_r}) + (gm >>> 4);
  assign d = t - $signed({{4{qsa[15]}}, qsa});
  assign ad = $signed({16'd0, a_r}) * d;
  assign n = $signed({{4{qsa[15]}}, qsa}) + (ad >>> 4);
  assign sat = n > 20'sd32767 ? 16'sh7fff : n < -20'sd32768 ? 16'sh8000 : n[15:0];
  // Read data lags its address by one cycle, so each state captures the previous read.
  always_ff @(posedge clk or negedge enb)
    if (!enb) begin
      st <= IDLE;
      q_addr <= '0;
      q_rd_en <= 1'b0;
      q_wr_en <= 1'b0;
      q_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cs_r <= '0;
      ns_r <= '0;
      ac_r <= '0;
      a_r <= '0;
      g_r <= '0;
      t_r <= 1'b0;
      rw_r <= '0;
      qsa <= '0;
      mx <= '0;
    end else
      case (st)
        IDLE: if (start) begin
          cs_r <= cur_st;
          ac_r <= act[1:0];
          ns_r <= next_st;
          t_r <= terminal;
          rw_r <= reward;
          a_r <= alpha;
          g_r <= gamma;
          busy <= 1'b1;
          done <= bad;
          err <= bad;
          q_rd_en <= !bad;
          if (!bad) q_addr <= {cur_st, act[1:0]};
          st <= bad ? WR : RDC;
        end
        RDC: begin
          q_rd_en <= !t_r;
          if (!t_r) q_addr <= {ns_r, 2'd0};
          st <= t_r ? WAIT : RN0;
        end
        RN0: begin
          qsa <= rd;
          q_addr <= {ns_r, 2'd1};
          st <= RN1;
        end
        RN1: begin
          mx <= rd;
          q_addr <= {ns_r, 2'd2};
          st <= RN2;
        end
        RN2: begin
          mx <= mx_nx;
          q_addr <= {ns_r, 2'd3};
          st <= RN3;
        end
        RN3: begin
          mx <= mx_nx;
          q_rd_en <= 1'b0;
          st <= WAIT;
        end
        WAIT: begin
          qsa <= t_r ? rd : qsa;
          mx <= t_r ? 16'sd0 : mx_nx;
          st <= CALC;
        end
        CALC: begin
          q_wr_en <= 1'b1;
          q_addr <= {cs_r, ac_r};
          q_wdata <= sat;
          done <= 1'b1;
          st <= WR;
        end
        WR: begin
          q_wr_en <= 1'b0;
          done <= 1'b0;
          err <= 1'b0;
          busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_q_update_seq.sv
// tb_q_update_seq: randomized and directed updates against an integer Bellman model,
// with a queue-based scoreboard checking RAM reads and the done/write cycle.
module tb_q_update_seq;
  logic clk = 0, enb = 0, start = 0, terminal = 0;
  logic [5:0] cur_st = 0, next_st = 0;
  logic [3:0] act = 0, alpha = 0, gamma = 0;
  logic [15:0] reward = 0, q_rdata = 0;
  logic [7:0] q_addr;
  logic q_rd_en, q_wr_en, busy, done, err;
  logic [15:0] q_wdata;
  logic pk_en = 0;
  logic [7:0] pk_a = 0;
  logic [15:0] pk_d = 0;
  logic [15:0] mem [256];
  logic [15:0] ref_q [256];
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {bit err; logic [7:0] addr; logic [15:0] data; int cyc;} exp_t;
  logic [7:0] rq [$];
  exp_t dq [$];

  q_update_seq dut (.clk(clk), .enb(enb), .start(start), .cur_st(cur_st), .act(act),
    .next_st(next_st), .terminal(terminal), .reward(reward), .alpha(alpha), .gamma(gamma),
    .q_addr(q_addr), .q_rd_en(q_rd_en), .q_rdata(q_rdata), .q_wr_en(q_wr_en),
    .q_wdata(q_wdata), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (q_rd_en) q_rdata <= mem[q_addr];
    if (q_wr_en) mem[q_addr] <= q_wdata;
    if (pk_en) mem[pk_a] <= pk_d;
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    pk_en = 1; pk_a = a; pk_d = v; ref_q[a] = v;
  endtask

  task automatic poke_end;
    @(negedge clk);
    pk_en = 0;
  endtask

  // Model: expected reads, result and done cycle derived from the update rules on ref_q.
  task automatic expect_upd(input logic [5:0] s, input logic [3:0] a, input logic [5:0] ns,
      input logic term, input logic [15:0] rw, input logic [3:0] al, input logic [3:0] gm, input int c0);
    exp_t e;
    int qsa, mq, t, d, n;
    logic [7:0] ad, na;
    e.err = 0; e.addr = 0; e.data = 0; e.cyc = c0;
    if (s < 1 || s > 25 || ns < 1 || ns > 25 || a > 3) begin
      e.err = 1;
      dq.push_back(e);
      return;
    end
    ad = {s, a[1:0]};
    rq.push_back(ad);
    qsa = int'($signed(ref_q[ad]));
    mq = 0;
    if (!term) begin
      mq = -32768;
      for (int k = 0; k < 4; k++) begin
        na = {ns, 2'(k)};
        rq.push_back(na);
        if (int'($signed(ref_q[na])) > mq) mq = int'($signed(ref_q[na]));
      end
    end
    t = int'($signed(rw)) + ((int'(gm) * mq) >>> 4);
    d = t - qsa;
    n = qsa + ((int'(al) * d) >>> 4);
    n = n > 32767 ? 32767 : n < -32768 ? -32768 : n;
    ref_q[ad] = 16'(n);
    e.addr = ad; e.data = 16'(n); e.cyc = c0 + (term ? 3 : 7);
    dq.push_back(e);
  endtask

  task automatic drive(input logic [5:0] s, input logic [3:0] a, input logic [5:0] ns,
      input logic term, input logic [15:0] rw, input logic [3:0] al, input logic [3:0] gm);
    cur_st = s; act = a; next_st = ns; terminal = term; reward = rw; alpha = al; gamma = gm;
    start = 1;
  endtask

  task automatic issue(input logic [5:0] s, input logic [3:0] a, input logic [5:0] ns,
      input logic term, input logic [15:0] rw, input logic [3:0] al, input logic [3:0] gm);
    @(negedge clk);
    drive(s, a, ns, term, rw, al, gm);
    @(posedge clk);
    #1 start = 0;
    expect_upd(s, a, ns, term, rw, al, gm, cyc);
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((dq.size() != 0 || rq.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(n < 40, "idle_timeout", n, 40);
  endtask

  task automatic chk_zero(input string tag);
    chk(q_addr == 0, {tag, "_q_addr"}, q_addr, 0);
    chk(q_rd_en == 0, {tag, "_q_rd_en"}, q_rd_en, 0);
    chk(q_wr_en == 0, {tag, "_q_wr_en"}, q_wr_en, 0);
    chk(q_wdata == 0, {tag, "_q_wdata"}, q_wdata, 0);
    chk(busy == 0, {tag, "_busy"}, busy, 0);
    chk(done == 0, {tag, "_done"}, done, 0);
    chk(err == 0, {tag, "_err"}, err, 0);
  endtask

  always @(negedge clk) if (enb) begin : mon
    exp_t e;
    logic [7:0] ea;
    chk(!(q_rd_en && q_wr_en), "rd_wr_exclusive", {q_rd_en, q_wr_en}, 0);
    if (q_rd_en) begin
      chk(rq.size() != 0, "rd_expected", q_addr, 0);
      if (rq.size() != 0) begin
        ea = rq.pop_front();
        chk(q_addr == ea, "rd_addr", q_addr, ea);
      end
    end
    if (done) begin
      chk(dq.size() != 0, "done_expected", cyc, 0);
      if (dq.size() != 0) begin
        e = dq.pop_front();
        chk(cyc == e.cyc, "done_cycle", cyc, e.cyc);
        chk(err == e.err, "err", err, e.err);
        chk(q_wr_en == !e.err, "wr_en", q_wr_en, !e.err);
        if (!e.err) begin
          chk(q_addr == e.addr, "wr_addr", q_addr, e.addr);
          chk(q_wdata == e.data, "wr_data", q_wdata, e.data);
        end
      end
    end else begin
      chk(!q_wr_en, "wr_without_done", q_wr_en, 0);
      chk(!err, "err_without_done", err, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] s, ns;
    logic [3:0] a, al, gm;
    logic [15:0] rw, old;
    logic term;
    int kind;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    enb = 1;
    for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom_range(0, 8191) - 4096));
    poke_end();
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 11);
      s = 6'($urandom_range(1, 25));
      ns = 6'($urandom_range(1, 25));
      a = 4'($urandom_range(0, 3));
      if (kind == 0) s = 0;
      if (kind == 1) ns = 6'($urandom_range(26, 63));
      if (kind == 2) a = 4'($urandom_range(4, 15));
      term = $urandom_range(0, 3) == 0;
      rw = 16'($urandom_range(0, 8191) - 4096);
      al = 4'($urandom_range(0, 15));
      gm = 4'($urandom_range(0, 8));
      issue(s, a, ns, term, rw, al, gm);
      wait_idle();
    end
    poke(8'h04, 16'h0000);
    poke(8'h08, 16'h0100);
    poke(8'h09, 16'h0200);
    poke(8'h0A, 16'h0080);
    poke(8'h0B, 16'hFF00);
    poke_end();
    issue(1, 0, 2, 0, 16'h0700, 8, 14);
    wait_idle();
    chk(mem[8'h04] == 16'h0460, "normal_result", mem[8'h04], 16'h0460);
    poke(8'h16, 16'h0200);
    poke_end();
    issue(5, 2, 7, 1, 16'h0A00, 8, 5);
    wait_idle();
    chk(mem[8'h16] == 16'h0600, "terminal_result", mem[8'h16], 16'h0600);
    poke(8'h29, 16'h7F00);
    for (int k = 0; k < 4; k++) poke(8'(8'h2C + k), 16'h7F00);
    poke_end();
    issue(10, 1, 11, 0, 16'h7F00, 15, 15);
    wait_idle();
    chk(mem[8'h29] == 16'h7FFF, "sat_pos", mem[8'h29], 16'h7FFF);
    poke(8'h33, 16'h8000);
    for (int k = 0; k < 4; k++) poke(8'(8'h34 + k), 16'h8000);
    poke_end();
    issue(12, 3, 13, 0, 16'h8000, 15, 15);
    wait_idle();
    chk(mem[8'h33] == 16'h8000, "sat_neg", mem[8'h33], 16'h8000);
    poke(8'h41, 16'h1234);
    poke_end();
    issue(16, 1, 17, 0, 16'h0500, 0, 7);
    wait_idle();
    chk(mem[8'h41] == 16'h1234, "alpha_zero", mem[8'h41], 16'h1234);
    for (int v = 0; v < 3; v++) begin
      issue(v == 1 ? 6'd0 : 6'd3, v == 0 ? 4'd4 : 4'd1, v == 2 ? 6'd26 : 6'd4, 0, 16'h0100, 4, 4);
      @(negedge clk);
      chk(busy == 1, "invalid_busy_c1", busy, 1);
      @(negedge clk);
      chk(busy == 0, "invalid_busy_c2", busy, 0);
    end
    // start held high: the second update must be accepted at edge 9.
    @(negedge clk);
    drive(2, 3, 3, 0, 16'h0300, 6, 7);
    @(posedge clk);
    #1 expect_upd(2, 3, 3, 0, 16'h0300, 6, 7, cyc);
    repeat (9) @(posedge clk);
    #1 expect_upd(2, 3, 3, 0, 16'h0300, 6, 7, cyc);
    start = 0;
    wait_idle();
    issue(4, 0, 5, 0, 16'h0200, 9, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(6, 1, 8, 0, 16'h0400, 5, 5);
    @(posedge clk);
    #1 start = 0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk(busy == 0, "pulse_ignored_busy", busy, 0);
    old = ref_q[8'h25];
    issue(9, 1, 10, 0, 16'h0600, 12, 6);
    repeat (2) @(posedge clk);
    #2 enb = 0;
    #1 chk_zero("async_reset");
    rq.delete();
    dq.delete();
    ref_q[8'h25] = old;
    repeat (3) @(negedge clk);
    enb = 1;
    chk(mem[8'h25] == old, "reset_no_write", mem[8'h25], old);
    issue(9, 1, 10, 0, 16'h0600, 12, 6);
    wait_idle();
    chk(mem[8'h25] == ref_q[8'h25], "post_reset_result", mem[8'h25], ref_q[8'h25]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/q_update_seq.md
# q_update_seq

Sequencer for the maze Q-learning Q-table update. On each agent step it reads Q(s,a) and the four Q(s',·) entries from the single-port Q-table RAM, then computes the Bellman update with saturating fixed-point arithmetic and writes the result back. It sits between the ControlUnit, which supplies state, action and reward, and the Q-table RAM. It owns the RAM port for the whole of an update.

## Interface
- STATES, 25, number of valid maze states; valid encodings are 1..STATES.
- clk  in  1  system clock, rising-edge.
- enb  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an update; sampled only in IDLE.
- cur_st  in  6  state s; captured at start.
- act  in  4  action a; valid values 0..3; captured at start.
- next_st  in  6  state s'; captured at start.
- terminal  in  1  s' is a goal or fail state, so maxQ(s') = 0; captured at start.
- reward  in  16  signed Q8.8 reward; captured at start.
- alpha  in  4  unsigned Q0.4 learning rate; captured at start.
- gamma  in  4  unsigned Q0.4 discount; captured at start.
- q_addr  out  8  RAM address {state[5:0], action[1:0]}.
- q_rd_en  out  1  RAM read strobe; data returns on q_rdata one cycle later.
- q_rdata  in  16  signed Q8.8 RAM read data.
- q_wr_en  out  1  RAM write strobe.
- q_wdata  out  16  signed Q8.8 write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse marking the end of an update.
- err  out  1  one-cycle pulse, coincident with done, when the request was invalid.

## Operation
- FSM states: IDLE, RDC, RN0, RN1, RN2, RN3, WAIT, CALC, WR.
- IDLE + start:
  - Register all inputs, then go to RDC.
  - A start that arrives in any other state is ignored and not queued.
- Invalid request: cur_st or next_st equals 0 or exceeds STATES, or act > 3.
  - The FSM goes to WR, which asserts done and err and does not assert q_wr_en.
  - The RAM is never touched.
- RDC: q_rd_en=1, q_addr={s,a}. Next state is RN0, or WAIT if terminal.
- RN0..RN3:
  - q_rd_en=1, q_addr={s',k} for k=0..3.
  - Each cycle captures the q_rdata returned for the previous address: Q(s,a) in RN0, then a running max.
- WAIT: captures the last outstanding read, which is Q(s',3), or Q(s,a) when terminal.
- maxQ:
  - Signed maximum of the four Q(s',k).
  - On ties the lowest k wins; this does not affect the value.
  - Forced to 0 when terminal.
- CALC, all signed with 20-bit intermediates and arithmetic right shift (floor):
  - t = reward + ((gamma*maxQ) >>> 4)
  - d = t − Q(s,a)
  - n = Q(s,a) + ((alpha*d) >>> 4)
  - n is saturated to [0x8000, 0x7FFF] and registered.
- WR: q_wr_en=1, q_addr={s,a}, q_wdata=n, done=1. Next state is IDLE.
- q_rd_en and q_wr_en are never asserted in the same cycle.
- q_addr holds its last value when no strobe is active.

## Timing
- Reset (enb=0, asynchronous) forces:
  - FSM to IDLE.
  - q_addr=0, q_rd_en=0, q_wr_en=0, q_wdata=0.
  - busy=0, done=0, err=0.
  - All internal registers cleared.
- Reset mid-update aborts immediately with no write. The first start after enb rises is accepted normally.
- All outputs are registered from FSM state.
- Cycle counts take start sampled at edge 0:
  - Non-terminal: RDC=1, RN0..RN3=2..5, WAIT=6, CALC=7, WR=8. q_wr_en and done are high in cycle 8, busy is high in cycles 1–8, IDLE is at 9.
  - Terminal: RDC=1, WAIT=2, CALC=3, WR=4.
  - Invalid: WR=1, so done and err are high in cycle 1.
- Back-to-back: start may be asserted in the first IDLE cycle after WR and is accepted. Minimum issue interval is 9 cycles (non-terminal).
- alpha=0: the write still occurs, with q_wdata = Q(s,a).

## Test plan
- Normal update:
  - Stimulus: alpha=8, gamma=14, reward=0x0700, Q(s=1,a=0)=0, Q(s'=2,·)={0x0100,0x0200,0x0080,0xFF00}.
  - Required: RAM reads in order at addresses 0x04, 0x08, 0x09, 0x0A, 0x0B. Write of 0x0460 to 0x04 in cycle 8, with done in the same cycle.
- Terminal:
  - Stimulus: reward=0x0A00, Q(s,a)=0x0200, alpha=8, terminal=1.
  - Required: exactly one read, then a write of 0x0600 in cycle 4.
- Saturation:
  - Stimulus: Q(s,a)=0x7F00, every Q(s',·)=0x7F00, reward=0x7F00, alpha=15, gamma=15.
  - Required: q_wdata=0x7FFF.
  - Stimulus: all values 0x8000, reward 0x8000.
  - Required: q_wdata=0x8000.
- Invalid:
  - Stimulus: act=4, or cur_st=0, or next_st=26.
  - Required: done and err in cycle 1, no RAM strobes, busy back low in cycle 2.
- Protocol:
  - Stimulus: start held high for the whole update.
  - Required: a second update begins exactly at cycle 9.
  - Stimulus: a pulse at cycle 4 only (start low at cycle 0 and any later edge).
  - Required: ignored.
- Reset:
  - Stimulus: enb low at cycle 3.
  - Required: all outputs 0 asynchronously and no write ever occurs; the next start completes a correct update.
